timer_multi: RTL and testbench

Parametrised multi-channel interval timer with an Avalon-MM slave interface and a 16-bit data bus. It is the next-generation interval timer for the processor subsystem. It provides NUM_CH independent down-counters, each with:
- a per-channel clock prescaler,
- one-shot or continuous mode,
- an atomic snapshot.

All channels drive one combined interrupt line, and a global pending register lets the ISR find the source in a single read.

---
 rtl/timer_multi_pkg.sv | 21 ++
 rtl/timer_multi_ch.sv | 126 ++++++++++++
 rtl/timer_multi.sv | 70 +++++++
 tb/tb_timer_multi.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_multi_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package timer_multi_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESC    = 3'd6;
  localparam logic [2:0] REG_PENDING  = 3'd7;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  localparam int unsigned STAT_TO  = 0;
  localparam int unsigned STAT_RUN = 1;

endpackage

// File: rtl/timer_multi_ch.sv
// One timer channel: prescaled down-counter, period/control/snapshot registers,
// sticky timeout on the rising edge of count==0, and the channel read mux.
module timer_multi_ch
  import timer_multi_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 999999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write,
  input  logic [2:0]  offset,
  input  logic [15:0] writedata,
  output logic        to,
  output logic        ito,
  output logic [15:0] rdata
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] snap;
  logic [CNT_W-1:0] period_wr;
  logic [15:0]      presc;
  logic [15:0]      presc_cnt;
  logic             cont;
  logic             run;
  logic             zero_d;
  logic             zero;
  logic             tick;
  logic             timeout;
  logic [31:0]      pw;
  logic [31:0]      period_ext;
  logic [31:0]      snap_ext;

  assign zero       = (count == '0);
  assign tick       = run && (presc_cnt == presc);
  assign timeout    = zero && !zero_d;
  assign period_ext = 32'(period);
  assign snap_ext   = 32'(snap);

  // Merge the written half into the current period so the counter loads the complete new value.
  always_comb begin
    pw = 32'(period);
    if (offset == REG_PERIOD_H) pw[31:16] = writedata;
    else                        pw[15:0]  = writedata;
    period_wr = pw[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= RST_VAL;
      period    <= RST_VAL;
      snap      <= '0;
      presc     <= '0;
      presc_cnt <= '0;
      ito       <= 1'b0;
      cont      <= 1'b0;
      run       <= 1'b0;
      to        <= 1'b0;
      zero_d    <= (RST_VAL == '0);
    end else begin
      zero_d <= zero;
      if (run) presc_cnt <= tick ? '0 : presc_cnt + 16'd1;
      if (tick) begin
        if (zero) begin
          count <= period;
          if (!cont) run <= 1'b0;
        end else begin
          count <= count - CNT_W'(1);
        end
      end
      // Later assignments give bus writes priority over the counter; START beats STOP.
      if (write) begin
        case (offset)
          REG_STATUS: to <= 1'b0;
          REG_CONTROL: begin
            ito  <= writedata[CTRL_ITO];
            cont <= writedata[CTRL_CONT];
            if (writedata[CTRL_STOP]) run <= 1'b0;
            if (writedata[CTRL_START]) begin
              run       <= 1'b1;
              presc_cnt <= '0;
            end
          end
          REG_PERIOD_L, REG_PERIOD_H: begin
            period    <= period_wr;
            count     <= period_wr;
            run       <= 1'b0;
            presc_cnt <= '0;
          end
          REG_SNAP_L, REG_SNAP_H: snap <= count;
          REG_PRESC: begin
            presc     <= writedata;
            presc_cnt <= '0;
          end
          default: ;
        endcase
      end
      // A fresh timeout outranks a simultaneous STATUS clear.
      if (timeout) to <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      REG_STATUS: begin
        rdata[STAT_TO]  = to;
        rdata[STAT_RUN] = run;
      end
      REG_CONTROL: begin
        rdata[CTRL_ITO]  = ito;
        rdata[CTRL_CONT] = cont;
      end
      REG_PERIOD_L: rdata = period_ext[15:0];
      REG_PERIOD_H: rdata = period_ext[31:16];
      REG_SNAP_L:   rdata = snap_ext[15:0];
      REG_SNAP_H:   rdata = snap_ext[31:16];
      REG_PRESC:    rdata = presc;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/timer_multi.sv
// Multi-channel interval timer with Avalon-MM slave: channel array, write decode,
// registered read mux, global PENDING register and combined interrupt.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 999999,
  parameter int unsigned ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq
);

  logic [ADDR_W-1:0] ch_sel;
  logic [2:0]        offset;
  logic              wr_en;
  logic [NUM_CH-1:0] ch_to;
  logic [NUM_CH-1:0] ch_ito;
  logic [15:0]       ch_rdata [NUM_CH];
  logic [15:0]       pending;
  logic [15:0]       rd_next;

  // Shift rather than slice so a single-channel build has no empty channel field.
  assign ch_sel = address >> 3;
  assign offset = address[2:0];
  assign wr_en  = chipselect && !write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_multi_ch #(
      .CNT_W       (CNT_W),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .write    (wr_en && (ch_sel == ADDR_W'(i))),
      .offset   (offset),
      .writedata(writedata),
      .to       (ch_to[i]),
      .ito      (ch_ito[i]),
      .rdata    (ch_rdata[i])
    );
  end

  always_comb begin
    pending = '0;
    pending[NUM_CH-1:0] = ch_to & ch_ito;
  end

  assign irq = |(ch_to & ch_ito);

  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i)) rd_next = (offset == REG_PENDING) ? pending : ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: directed scenarios plus random bus traffic,
// checked against a behavioural per-channel timer model.
module tb_timer_multi;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 32;
  localparam int unsigned RP  = 999999;
  localparam int unsigned AW  = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [15:0]   readdata;
  logic          irq;

  always #5 clk = ~clk;

  timer_multi #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .RESET_PERIOD(RP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  // Model: m_phase counts clocks since the last decrement opportunity.
  int unsigned m_cnt   [NCH];
  int unsigned m_per   [NCH];
  int unsigned m_snap  [NCH];
  int unsigned m_presc [NCH];
  int unsigned m_phase [NCH];
  logic        m_ito   [NCH];
  logic        m_cont  [NCH];
  logic        m_run   [NCH];
  logic        m_to    [NCH];
  logic        m_zero_prev [NCH];

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  function automatic void check16(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h required 0x%04h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int unsigned c = 0; c < NCH; c++) begin
      m_cnt[c] = RP; m_per[c] = RP; m_snap[c] = 0; m_presc[c] = 0; m_phase[c] = 0;
      m_ito[c] = 1'b0; m_cont[c] = 1'b0; m_run[c] = 1'b0; m_to[c] = 1'b0;
      m_zero_prev[c] = (RP == 0);
    end
  endfunction

  function automatic logic model_irq();
    logic r;
    r = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) r = r | (m_to[c] & m_ito[c]);
    return r;
  endfunction

  function automatic logic [15:0] model_read(logic [AW-1:0] a);
    int unsigned c;
    int unsigned off;
    logic [15:0] pend;
    c = 32'(a[AW-1:3]);
    off = 32'(a[2:0]);
    pend = '0;
    for (int unsigned k = 0; k < NCH; k++) pend[k] = m_to[k] & m_ito[k];
    if (c >= NCH) return 16'h0000;
    case (off)
      0: return {14'd0, m_run[c], m_to[c]};
      1: return {14'd0, m_cont[c], m_ito[c]};
      2: return 16'(m_per[c]);
      3: return 16'(m_per[c] >> 16);
      4: return 16'(m_snap[c]);
      5: return 16'(m_snap[c] >> 16);
      6: return 16'(m_presc[c]);
      default: return pend;
    endcase
  endfunction

  function automatic void model_step(logic we, logic [AW-1:0] a, logic [15:0] d);
    int unsigned wch;
    int unsigned off;
    int unsigned cnt_before;
    logic at_zero;
    logic fire;
    logic tick;
    wch = 32'(a[AW-1:3]);
    off = 32'(a[2:0]);
    for (int unsigned c = 0; c < NCH; c++) begin
      cnt_before = m_cnt[c];
      at_zero = (m_cnt[c] == 0);
      fire = at_zero && !m_zero_prev[c];
      tick = m_run[c] && (m_phase[c] == m_presc[c]);
      if (tick) begin
        m_phase[c] = 0;
        if (at_zero) begin
          m_cnt[c] = m_per[c];
          if (!m_cont[c]) m_run[c] = 1'b0;
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end else if (m_run[c]) begin
        m_phase[c] = m_phase[c] + 1;
      end
      if (we && wch == c) begin
        case (off)
          0: m_to[c] = 1'b0;
          1: begin
            m_ito[c] = d[0];
            m_cont[c] = d[1];
            if (d[3]) m_run[c] = 1'b0;
            if (d[2]) begin m_run[c] = 1'b1; m_phase[c] = 0; end
          end
          2, 3: begin
            if (off == 2) m_per[c] = (m_per[c] & 32'hFFFF_0000) | 32'(d);
            else          m_per[c] = (m_per[c] & 32'h0000_FFFF) | (32'(d) << 16);
            m_cnt[c] = m_per[c];
            m_run[c] = 1'b0;
            m_phase[c] = 0;
          end
          4, 5: m_snap[c] = cnt_before;
          6: begin m_presc[c] = 32'(d); m_phase[c] = 0; end
          default: ;
        endcase
      end
      if (fire) m_to[c] = 1'b1;
      m_zero_prev[c] = at_zero;
    end
  endfunction

  // One bus cycle: expected readdata is taken from the model before the edge, queued after it.
  task automatic bus(input logic cs, input logic wr_, input int unsigned ch, input int unsigned off,
                     input logic [15:0] d, input string cname, input logic has_const,
                     input logic [15:0] cval);
    logic [15:0] e;
    logic [AW-1:0] a;
    a = AW'(ch * 8 + off);
    chipselect = cs;
    write_n = ~wr_;
    address = a;
    writedata = d;
    e = reset_n ? model_read(a) : 16'h0000;
    @(posedge clk);
    if (reset_n) model_step(cs & wr_, a, d);
    sb_q.push_back('{exp: e, name: $sformatf("rd_ch%0d_off%0d", ch, off)});
    if (has_const) sb_q.push_back('{exp: cval, name: cname});
    @(negedge clk);
  endtask

  task automatic wr(input int unsigned ch, input int unsigned off, input logic [15:0] d);
    bus(1'b1, 1'b1, ch, off, d, "", 1'b0, 16'h0000);
  endtask

  task automatic rd(input int unsigned ch, input int unsigned off);
    bus(1'b1, 1'b0, ch, off, 16'h0000, "", 1'b0, 16'h0000);
  endtask

  task automatic rd_expect(input int unsigned ch, input int unsigned off, input logic [15:0] v,
                           input string cname);
    bus(1'b1, 1'b0, ch, off, 16'h0000, cname, 1'b1, v);
  endtask

  always @(negedge clk) begin
    sb_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check16(it.name, readdata, it.exp);
    end
    check1("irq", irq, model_irq());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ch;
    int unsigned k;
    logic found;
    model_reset();
    bus(1'b0, 1'b0, 0, 0, 16'h0000, "", 1'b0, 16'h0000);
    bus(1'b0, 1'b0, 0, 0, 16'h0000, "", 1'b0, 16'h0000);
    reset_n = 1'b1;

    // Reset values
    rd_expect(0, 2, 16'h423F, "rst_per_l");
    rd_expect(0, 3, 16'h000F, "rst_per_h");
    rd_expect(1, 0, 16'h0000, "rst_status");
    check1("rst_irq", irq, 1'b0);

    // Continuous channel 2, period 9, no prescale
    wr(2, 2, 16'd9);
    wr(2, 3, 16'd0);
    wr(2, 6, 16'd0);
    wr(2, 1, 16'h0007);
    for (int n = 0; n < 25; n++) rd(2, 0);
    rd_expect(2, 7, 16'h0004, "pending_ch2");

    // One-shot channel 0, period 3, prescale 1
    wr(0, 2, 16'd3);
    wr(0, 3, 16'd0);
    wr(0, 6, 16'd1);
    wr(0, 1, 16'h0004);
    for (int n = 0; n < 12; n++) rd(0, 0);
    wr(0, 4, 16'h0000);
    rd_expect(0, 4, 16'h0003, "oneshot_reload_hold");
    rd_expect(0, 0, 16'h0001, "oneshot_status");

    // STATUS clear in the same cycle as a timeout event
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      if (m_cnt[2] == 0 && !m_zero_prev[2]) begin
        wr(2, 0, 16'h0000);
        found = 1'b1;
      end else begin
        rd(2, 0);
      end
    end
    check1("to_sync_found", found, 1'b1);
    rd_expect(2, 0, 16'h0003, "to_wins_over_clear");
    wr(2, 0, 16'h0000);
    rd_expect(2, 0, 16'h0002, "status_clear_run");

    // START and STOP together
    wr(0, 1, 16'h000C);
    rd_expect(0, 0, 16'h0003, "start_wins");

    // Snapshot while running, then period write mid-count
    wr(0, 4, 16'h0000);
    rd(0, 4);
    rd(0, 5);
    wr(0, 2, 16'h0020);
    rd_expect(0, 0, 16'h0001, "per_wr_stops");
    wr(0, 4, 16'h0000);
    rd_expect(0, 4, 16'h0020, "per_wr_loads");
    rd_expect(0, 5, 16'h0000, "per_wr_loads_h");

    // Unimplemented channel slot
    rd_expect(3, 0, 16'h0000, "slot3_status");
    wr(3, 2, 16'd5);
    wr(3, 1, 16'h0007);
    rd_expect(3, 2, 16'h0000, "slot3_period");
    rd_expect(3, 7, 16'h0000, "slot3_pending");
    rd_expect(0, 2, 16'h0020, "slot3_no_alias");

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      ch = $urandom_range(3, 0);
      k = $urandom_range(9, 0);
      case (k)
        0, 1, 2, 3: rd(ch, $urandom_range(7, 0));
        4: begin
          wr(ch, 2, 16'($urandom_range(12, 0)));
          wr(ch, 3, 16'h0000);
        end
        5: wr(ch, 6, 16'($urandom_range(3, 0)));
        6: wr(ch, 1, 16'($urandom_range(15, 0)));
        7: wr(ch, 0, 16'($urandom));
        8: wr(ch, $urandom_range(5, 4), 16'($urandom));
        default: bus(1'b0, 1'b1, ch, $urandom_range(7, 0), 16'($urandom), "", 1'b0, 16'h0000);
      endcase
    end

    // Asynchronous reset mid-count
    wr(1, 2, 16'd5);
    wr(1, 3, 16'd0);
    wr(1, 6, 16'd0);
    wr(1, 1, 16'h0007);
    for (int n = 0; n < 9; n++) rd(1, 1);
    #2 reset_n = 1'b0;
    #1;
    check16("async_rst_readdata", readdata, 16'h0000);
    check1("async_rst_irq", irq, 1'b0);
    model_reset();
    @(negedge clk);
    bus(1'b1, 1'b0, 1, 1, 16'h0000, "", 1'b0, 16'h0000);
    bus(1'b1, 1'b0, 1, 1, 16'h0000, "", 1'b0, 16'h0000);
    reset_n = 1'b1;
    rd_expect(1, 0, 16'h0000, "post_rst_status");
    rd_expect(1, 2, 16'h423F, "post_rst_per_l");
    rd_expect(1, 3, 16'h000F, "post_rst_per_h");
    rd_expect(2, 6, 16'h0000, "post_rst_presc");
    rd_expect(2, 4, 16'h0000, "post_rst_snap");
    rd(0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
